// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver.
// Provides the parity mode and receiver state enums plus small helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Encoding 3 is reserved and behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] p);
        parity_t r;
        unique case (p)
            2'd1:    r = PAR_EVEN;
            2'd2:    r = PAR_ODD;
            default: r = PAR_NONE;
        endcase
        return r;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side consumer handshake of uart_rx_cfg.
// master: receiver drives o_data/o_perr/o_valid; slave: consumer drives i_ready.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_perr;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output o_data,
        output o_perr,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_perr,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with zero-latency head output (rdata = head when not empty).
// Ports: push/wdata, pop/rdata, full, empty, count (occupancy 0..DEPTH).
module uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push while full is only accepted if the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with 3-sample majority voting and RX FIFO.
// Ports: clk/rst, i_rxd, config (i_div/i_data_bits/i_parity/i_two_stop), rx handshake, status/error pulses.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rxd,
    input  logic [DIV_WIDTH-1:0]          i_div,
    input  logic [3:0]                    i_data_bits,
    input  logic [1:0]                    i_parity,
    input  logic                          i_two_stop,
    uart_rx_cfg_if.master                 rx,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy,
    output logic                          o_frame_error,
    output logic                          o_overrun_error,
    output logic                          o_break
);
    logic sync1, sync2, sync_d;
    logic start_det;

    rx_state_t             state, state_nxt;
    logic [DIV_WIDTH-1:0]  timer;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [3:0]            nbits_q;
    parity_t               par_q;
    logic                  two_q;
    logic [3:0]            bit_cnt;
    logic                  stop2;
    logic                  samp2, samp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_q;
    logic                  pvote_q;
    logic                  push_q;
    logic                  ferr_q, brk_q;

    logic tick, vote, par_exp;
    logic ferr_set, brk_set, push_set;

    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]   fifo_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= i_rxd;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign start_det = sync_d & ~sync2;
    assign tick      = (timer == '0);
    assign vote      = maj3(samp2, samp1, sync2);
    assign par_exp   = (par_q == PAR_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ferr_set  = 1'b0;
        brk_set   = 1'b0;
        push_set  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_det) state_nxt = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (vote) begin
                        state_nxt = ST_IDLE;
                        ferr_set  = 1'b1;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick && bit_cnt == nbits_q - 4'd1) begin
                    state_nxt = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (!vote) begin
                        state_nxt = ST_IDLE;
                        ferr_set  = 1'b1;
                        // Line held low through the whole frame: a break.
                        brk_set   = (shreg == '0) &&
                                    !(par_q != PAR_NONE && pvote_q);
                    end else if (two_q && !stop2) begin
                        state_nxt = ST_STOP;
                    end else begin
                        state_nxt = ST_IDLE;
                        push_set  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            div_q   <= '0;
            nbits_q <= '0;
            par_q   <= PAR_NONE;
            two_q   <= 1'b0;
            bit_cnt <= '0;
            stop2   <= 1'b0;
            samp2   <= 1'b1;
            samp1   <= 1'b1;
            shreg   <= '0;
            perr_q  <= 1'b0;
            pvote_q <= 1'b0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            ferr_q <= ferr_set;
            brk_q  <= brk_set;
            push_q <= push_set;
            if (timer == DIV_WIDTH'(2)) samp2 <= sync2;
            if (timer == DIV_WIDTH'(1)) samp1 <= sync2;
            if (!tick) timer <= timer - DIV_WIDTH'(1);
            unique case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        div_q   <= i_div;
                        nbits_q <= i_data_bits;
                        par_q   <= decode_parity(i_parity);
                        two_q   <= i_two_stop;
                        timer   <= (i_div >> 1) - DIV_WIDTH'(1);
                        shreg   <= '0;
                        bit_cnt <= '0;
                        stop2   <= 1'b0;
                        perr_q  <= 1'b0;
                        pvote_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) timer <= div_q - DIV_WIDTH'(1);
                end
                ST_DATA: begin
                    if (tick) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt == 4'(i)) shreg[i] <= vote;
                        end
                        bit_cnt <= bit_cnt + 4'd1;
                        timer   <= div_q - DIV_WIDTH'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        pvote_q <= vote;
                        perr_q  <= vote ^ par_exp;
                        timer   <= div_q - DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        stop2 <= 1'b1;
                        timer <= div_q - DIV_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata ({perr_q, shreg}),
        .pop   (rx.i_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign rx.o_valid     = ~fifo_empty;
    assign rx.o_data      = fifo_rdata[DATA_WIDTH-1:0];
    assign rx.o_perr      = fifo_rdata[DATA_WIDTH];
    assign o_busy         = (state != ST_IDLE);
    assign o_frame_error  = ferr_q;
    assign o_break        = brk_q;
    // Full implies not empty, so i_ready alone tells whether a pop frees a slot.
    assign o_overrun_error = push_q & fifo_full & ~rx.i_ready;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg (FIFO_DEPTH=4, div=16).
// Frame table plus hand sequences; popped FIFO data checked against a scoreboard queue.
module tb_uart_rx_cfg;
    localparam int DW  = 8;
    localparam int FD  = 4;
    localparam int DVW = 16;
    localparam int DIV = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_rxd;
    logic [DVW-1:0]   i_div;
    logic [3:0]       i_data_bits;
    logic [1:0]       i_parity;
    logic             i_two_stop;
    logic [$clog2(FD):0] o_count;
    logic             o_busy, o_frame_error, o_overrun_error, o_break;

    uart_rx_cfg_if #(.DATA_WIDTH(DW)) rx ();

    uart_rx_cfg #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .DIV_WIDTH  (DVW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rxd           (i_rxd),
        .i_div           (i_div),
        .i_data_bits     (i_data_bits),
        .i_parity        (i_parity),
        .i_two_stop      (i_two_stop),
        .rx              (rx.master),
        .o_count         (o_count),
        .o_busy          (o_busy),
        .o_frame_error   (o_frame_error),
        .o_overrun_error (o_overrun_error),
        .o_break         (o_break)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;
    int brk_cnt  = 0;
    int ovr_cnt  = 0;
    logic [8:0] sb [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_error)   ferr_cnt++;
            if (o_break)         brk_cnt++;
            if (o_overrun_error) ovr_cnt++;
            if (rx.o_valid && rx.i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("pop_data", int'(rx.o_data), int'(e[7:0]));
                    check("pop_perr", int'(rx.o_perr), int'(e[8]));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_rxd = b;
        cyc(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input logic [1:0] par, input logic pb,
                              input logic two, input logic s2);
        i_data_bits = 4'(nb);
        i_parity    = par;
        i_two_stop  = two;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (par == 2'd1 || par == 2'd2) drive_bit(pb);
        drive_bit(1'b1);
        if (two) drive_bit(s2);
        i_rxd = 1'b1;
        cyc(2 * DIV);
    endtask

    task automatic drain();
        int k;
        rx.i_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || rx.o_valid) && k < 200) begin
            cyc(1);
            k++;
        end
        check("drain_timeout", int'(k >= 200), 0);
        rx.i_ready = 1'b0;
        cyc(2);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nbits;
        logic [1:0] par;
        logic       pb;
        logic       two;
        logic       s2;
        logic       exp_push;
        logic       exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int f0, b0, o0;
        vecs[0] = '{8'hA5, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h35, 7, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h35, 7, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h3C, 8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h5A, 8, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[5] = '{8'h1F, 5, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[6] = '{8'h00, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[7] = '{8'h81, 8, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[8] = '{8'h2A, 6, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vecs[9] = '{8'h15, 5, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};

        rst = 1'b1;
        i_rxd = 1'b1;
        i_div = DVW'(DIV);
        i_data_bits = 4'd8;
        i_parity = 2'd0;
        i_two_stop = 1'b0;
        rx.i_ready = 1'b0;
        cyc(4);
        check("rst_count", int'(o_count), 0);
        check("rst_valid", int'(rx.o_valid), 0);
        check("rst_busy",  int'(o_busy), 0);
        check("rst_data",  int'(rx.o_data), 0);
        check("rst_perr",  int'(rx.o_perr), 0);
        check("rst_pulses", int'({o_frame_error, o_break, o_overrun_error}), 0);
        rst = 1'b0;
        cyc(4);

        foreach (vecs[i]) begin
            f0 = ferr_cnt;
            b0 = brk_cnt;
            if (vecs[i].exp_push) sb.push_back({vecs[i].exp_perr, vecs[i].data});
            send_frame(vecs[i].data, vecs[i].nbits, vecs[i].par,
                       vecs[i].pb, vecs[i].two, vecs[i].s2);
            check($sformatf("v%0d_count", i), int'(o_count), int'(vecs[i].exp_push));
            check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("v%0d_brk", i), brk_cnt - b0, 0);
            check($sformatf("v%0d_busy", i), int'(o_busy), 0);
            drain();
        end

        // One-clock glitch on the idle line.
        f0 = ferr_cnt;
        i_rxd = 1'b0;
        cyc(1);
        i_rxd = 1'b1;
        cyc(3 * DIV);
        check("glitch_ferr", ferr_cnt - f0, 1);
        check("glitch_count", int'(o_count), 0);

        // Overrun with FIFO_DEPTH=4.
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back({1'b0, 8'(i)});
            send_frame(8'(i), 8, 2'd0, 1'b0, 1'b0, 1'b1);
        end
        check("ovr_count", int'(o_count), 4);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_head", int'(rx.o_data), 1);
        drain();
        check("ovr_sb_empty", sb.size(), 0);

        // Break: line low for 12 bit times.
        f0 = ferr_cnt;
        b0 = brk_cnt;
        i_rxd = 1'b0;
        cyc(12 * DIV);
        i_rxd = 1'b1;
        cyc(2 * DIV);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_brk", brk_cnt - b0, 1);
        check("brk_count", int'(o_count), 0);
        sb.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 8, 2'd0, 1'b0, 1'b0, 1'b1);
        check("brk_next_count", int'(o_count), 1);
        drain();

        // Reset in the middle of DATA with one entry held in the FIFO.
        send_frame(8'h77, 8, 2'd0, 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", int'(o_count), 1);
        f0 = ferr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("mid_busy", int'(o_busy), 1);
        rst = 1'b1;
        cyc(1);
        check("mrst_count", int'(o_count), 0);
        check("mrst_valid", int'(rx.o_valid), 0);
        check("mrst_busy",  int'(o_busy), 0);
        check("mrst_data",  int'(rx.o_data), 0);
        check("mrst_pulses", int'({o_frame_error, o_break, o_overrun_error}), 0);
        i_rxd = 1'b1;
        rst = 1'b0;
        cyc(2 * DIV);
        check("post_rst_ferr", ferr_cnt - f0, 0);
        check("post_rst_count", int'(o_count), 0);
        sb.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 8, 2'd0, 1'b0, 1'b0, 1'b1);
        check("c3_count", int'(o_count), 1);
        drain();
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
